// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types for the cacheline arbiter: the arbitration FSM state encoding,
//   the latched operation type, and a small index helper used for the
//   round-robin pointer.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // Arbitration FSM: IDLE picks a channel, BUSY owns the memory port until the
  // downstream completion, DONE pulses the per-channel response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operation latched at grant time.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // (idx + 1) mod n for idx in [0, n-1]; avoids a divider for the RR pointer.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Purely combinational priority picker. Scans the request vector starting at
//   i_base and moving upward with wrap-around; the first set bit wins.
//
//   Ports
//     i_req        in   NUM_CH  request vector (one bit per channel)
//     i_base       in   IDX_W   channel with highest priority this scan
//     o_grant_oh   out  NUM_CH  one-hot grant (all zero when no request)
//     o_grant_idx  out  IDX_W   binary index of the granted channel
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_base,
  output logic [NUM_CH-1:0] o_grant_oh,
  output logic [IDX_W-1:0]  o_grant_idx
);

  always_comb begin
    logic             found;
    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // NOTE: every output and temporary gets a default before the loop so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    o_grant_oh  = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    pos         = 0;
    pos_idx     = '0;

    for (int k = 0; k < NUM_CH; k++) begin
      // Wrap by subtraction: base and k are both below NUM_CH.
      pos = int'(i_base) + k;
      if (pos >= NUM_CH) begin
        pos = pos - NUM_CH;
      end
      pos_idx = IDX_W'(pos);

      if (!found && i_req[pos_idx]) begin
        found               = 1'b1;
        o_grant_oh[pos_idx] = 1'b1;
        o_grant_idx         = pos_idx;
      end
    end
  end

endmodule : rr_picker

// File: rtl/line_arbiter_n.sv
// -----------------------------------------------------------------------------
// line_arbiter_n
//   Arbitrates NUM_CH cacheline read/write requesters onto a single downstream
//   memory port. One transaction is in flight at a time:
//     IDLE -> pick a channel, latch its op/address/data, drive the memory port
//     BUSY -> hold the memory request stable until mem_resp
//     DONE -> one-cycle ch_resp pulse to the granted channel, no arbitration
//   Priority is round-robin (RR_EN=1, base = pointer past the last grant) or
//   fixed (RR_EN=0, channel 0 highest). A channel with both read and write set
//   is serviced as a read first; its write is taken on a later arbitration.
//
//   Ports
//     clk        in   1              rising-edge clock
//     reset_n    in   1              asynchronous active-low reset
//     ch_read    in   NUM_CH         per-channel read request
//     ch_write   in   NUM_CH         per-channel write request
//     ch_addr    in   NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
//     ch_wdata   in   NUM_CH*LINE_W  channel i at [i*LINE_W +: LINE_W]
//     ch_rdata   out  LINE_W         last read line, broadcast to all channels
//     ch_resp    out  NUM_CH         one-cycle completion pulse, at most one hot
//     mem_read   out  1              downstream read
//     mem_write  out  1              downstream write
//     mem_addr   out  ADDR_W         downstream address
//     mem_wdata  out  LINE_W         downstream write line
//     mem_rdata  in   LINE_W         downstream read line
//     mem_resp   in   1              downstream completion (ignored outside BUSY)
// -----------------------------------------------------------------------------
module line_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 4,    // 2..8
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int RR_EN  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_resp
);

  localparam int IDX_W = $clog2(NUM_CH);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [NUM_CH-1:0]   r_grant_oh;
  op_e                 r_op;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_wdata;
  logic [NUM_CH-1:0]   r_ch_resp;
  logic [LINE_W-1:0]   r_ch_rdata;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_e              w_state_nxt;
  logic                w_load;       // IDLE with a request: take the grant
  logic                w_complete;   // BUSY with mem_resp: finish the access
  logic                w_release;    // DONE: advance the RR pointer
  logic [NUM_CH-1:0]   w_req;
  logic [IDX_W-1:0]    w_base;
  logic [NUM_CH-1:0]   w_grant_oh;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_pick_read;
  logic [ADDR_W-1:0]   w_ch_addr  [NUM_CH];
  logic [LINE_W-1:0]   w_ch_wdata [NUM_CH];

  // Unpack the flat per-channel buses so the grant index can select directly.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign w_ch_addr[i]  = ch_addr[i*ADDR_W +: ADDR_W];
    assign w_ch_wdata[i] = ch_wdata[i*LINE_W +: LINE_W];
  end

  // A channel competes if it has either operation pending.
  assign w_req  = ch_read | ch_write;
  assign w_base = (RR_EN != 0) ? r_ptr : '0;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .i_req       (w_req),
    .i_base      (w_base),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx)
  );

  // Read wins when the granted channel asserts both; its write stays pending
  // and is picked up by a later arbitration.
  assign w_pick_read = ch_read[w_grant_idx];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (|w_req)   w_state_nxt = BUSY;
      BUSY:    if (mem_resp) w_state_nxt = DONE;
      DONE:                  w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (strobes consumed by the datapath registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load     = 1'b0;
    w_complete = 1'b0;
    w_release  = 1'b0;
    unique case (r_state)
      IDLE:    w_load     = |w_req;
      BUSY:    w_complete = mem_resp;
      DONE:    w_release  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_grant_idx <= '0;
      r_grant_oh  <= '0;
      r_op        <= OP_READ;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ch_resp   <= '0;
      r_ch_rdata  <= '0;
    end else begin
      // ch_resp is a single-cycle pulse: cleared unless set below.
      r_ch_resp <= '0;

      // Grant: everything the memory port needs is captured here, so later
      // changes on the ch_* inputs cannot disturb the in-flight transaction.
      if (w_load) begin
        r_grant_idx <= w_grant_idx;
        r_grant_oh  <= w_grant_oh;
        r_op        <= w_pick_read ? OP_READ : OP_WRITE;
        r_mem_read  <= w_pick_read;
        r_mem_write <= !w_pick_read;
        r_mem_addr  <= w_ch_addr[w_grant_idx];
        r_mem_wdata <= w_ch_wdata[w_grant_idx];
      end

      // Completion: drop the memory request, capture read data, and arm the
      // response pulse that is visible during DONE.
      if (w_complete) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_ch_resp   <= r_grant_oh;
        if (r_op == OP_READ) begin
          r_ch_rdata <= mem_rdata;
        end
      end

      // The pointer moves only once per finished transaction, so the granted
      // channel drops to lowest priority for the next pick.
      if (w_release && (RR_EN != 0)) begin
        r_ptr <= IDX_W'(wrap_inc(int'(r_grant_idx), NUM_CH));
      end
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ch_resp   = r_ch_resp;
  assign ch_rdata  = r_ch_rdata;

endmodule : line_arbiter_n

// File: doc/line_arbiter_n.md
LINE_ARBITER_N -- requirements
Module: line_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-004 SHALL have parameter RR_EN, default 1: 1 = round-robin priority; 0 = fixed priority, with channel 0 highest.
REQ-005 SHALL have the following ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ch_read  in  NUM_CH  per-channel line read request.
- ch_write  in  NUM_CH  per-channel line write request.
- ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line; same packing as ch_addr.
- ch_rdata  out  LINE_W  read line, broadcast to all channels.
- ch_resp  out  NUM_CH  per-channel one-cycle completion pulse.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  LINE_W  downstream write line.
- mem_rdata  in  LINE_W  downstream read line.
- mem_resp  in  1  downstream completion.

Function
REQ-006 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-007 IDLE: if any ch_read|ch_write bit is set, SHALL pick one channel, register its index, operation, address and wdata, and go to BUSY.
- If no request is set, SHALL stay in IDLE.
REQ-008 The pick SHALL scan channels starting at the priority base, upward with wrap. The base is ptr when RR_EN=1 and 0 when RR_EN=0.
REQ-009 When both ch_read[i] and ch_write[i] are set, the read SHALL be serviced first; the write is taken on a later arbitration.
REQ-010 BUSY: mem_read or mem_write SHALL be asserted from the latched operation, with mem_addr and mem_wdata held stable, until mem_resp is seen.
- Latency from request in IDLE to mem_read/mem_write asserted: exactly 1 cycle.
REQ-011 On mem_resp in BUSY:
- mem_read and mem_write SHALL deassert on the next cycle.
- mem_rdata SHALL be registered into ch_rdata on a read.
- The FSM SHALL go to DONE.
REQ-012 DONE: ch_resp[granted] SHALL be high for exactly one cycle and ch_rdata SHALL be valid; the FSM SHALL then go to IDLE.
- Arbitration SHALL not occur in DONE, giving the requester a cycle to drop or change its request.
REQ-013 ch_rdata SHALL hold its value until the next read completion.
REQ-014 When RR_EN=1, ptr SHALL update to (granted+1) mod NUM_CH on the DONE cycle; ptr SHALL not change otherwise.
REQ-015 A granted transaction SHALL not be aborted: changes to ch_* inputs after the grant are ignored until DONE.
REQ-016 A request that drops before it is granted SHALL be discarded with no side effect.
REQ-017 When RR_EN=1, a continuously asserted request SHALL be granted within NUM_CH-1 transactions of any other channel.
REQ-018 mem_resp arriving outside BUSY SHALL be ignored.
REQ-019 At most one ch_resp bit SHALL be set in any cycle.

Reset
REQ-020 On reset_n low, asynchronously, the block SHALL set:
- state = IDLE, ptr = 0.
- mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
- ch_resp = 0, ch_rdata = 0.
REQ-021 Reset mid-transaction SHALL drop the transaction with no ch_resp issued; the first grant after reset release uses base 0.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the op typedef (OP_READ, OP_WRITE).
REQ-023 Sub-module rr_picker SHALL be combinational: inputs are the request vector and base; outputs are a one-hot grant and the grant index.
- line_arbiter_n SHALL instantiate it once.

Verification
REQ-024 Single read: ch_read[2]=1, addr 0x0000_1040; mem_resp after 5 cycles with rdata 0xA5.. -> mem_read rises 1 cycle after request, mem_addr=0x1040, ch_resp[2] pulses 1 cycle after mem_resp, ch_rdata=0xA5...
REQ-025 Round-robin fairness: NUM_CH=4, RR_EN=1, all four ch_read held high, mem_resp 3 cycles after each issue -> grant order 0,1,2,3,0.
REQ-026 Fixed priority: RR_EN=0, ch_read[0] and ch_read[3] held high -> channel 0 granted every transaction, channel 3 never granted.
REQ-027 Read/write collision: ch_read[1]=ch_write[1]=1, wdata 0x5A.. -> read issued first; write issued after DONE with mem_wdata=0x5A...
REQ-028 Reset mid-op: reset_n low 2 cycles into BUSY -> mem_read=0 and ch_resp=0 immediately; no pulse after release; ptr=0.
REQ-029 Stray response: mem_resp pulsed while IDLE -> no ch_resp, no state change.
